uc_pilha_param: RTL and testbench

Parametrised control unit for the stack processor. It fetches instructions from ROM through a program counter and decodes them. It sequences RAM, stack, temp registers and ALU through single-cycle enable strobes, with no generated clocks. Over the previous generation it adds PC increment and wrap, immediate branches, HALT, start/restart, a tracked stack pointer with overflow, underflow and illegal-opcode trapping, and parametrised widths.

---
 rtl/uc_pilha_param.sv | 228 ++++++++++++++++++++++
 tb/tb_uc_pilha_param.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uc_pilha_param.sv
// Control unit for the stack processor: fetches from ROM, decodes, and sequences RAM, stack,
// temp registers and ALU through one-cycle strobes while tracking stack occupancy and traps.

module uc_pilha_param #(
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned ADDR_W      = 5,
   parameter int unsigned PC_W        = 5,
   parameter int unsigned OP_W        = 5,
   parameter int unsigned STACK_DEPTH = 16,
   localparam int unsigned SP_W       = $clog2(STACK_DEPTH + 1)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     start,
   input  logic [OP_W+ADDR_W-1:0]   inst,
   input  logic [DATA_W-1:0]        data_mem,
   input  logic                     controle_ula,
   output logic [PC_W-1:0]          a_rom,
   output logic                     rom_en,
   output logic [ADDR_W-1:0]        a_ram,
   output logic                     ram_en,
   output logic                     ram_wren,
   output logic                     pilha_en,
   output logic                     pilha_wren,
   output logic                     controle_pilha,
   output logic [DATA_W-1:0]        data_pilha,
   output logic                     load_temp1,
   output logic                     load_temp2,
   output logic [OP_W-1:0]          opcode,
   output logic [SP_W-1:0]          sp,
   output logic                     busy,
   output logic                     halted,
   output logic                     erro,
   output logic [1:0]               erro_cod
);

   localparam logic [3:0] StIdle   = 4'd0;
   localparam logic [3:0] StFetch  = 4'd1;
   localparam logic [3:0] StDecode = 4'd2;
   localparam logic [3:0] StRd     = 4'd3;
   localparam logic [3:0] StPushWr = 4'd4;
   localparam logic [3:0] StExec   = 4'd5;
   localparam logic [3:0] StWb     = 4'd6;
   localparam logic [3:0] StPopA   = 4'd7;
   localparam logic [3:0] StWr     = 4'd8;
   localparam logic [3:0] StLoadA  = 4'd9;
   localparam logic [3:0] StPopB   = 4'd10;
   localparam logic [3:0] StLoadB  = 4'd11;
   localparam logic [3:0] StBrEval = 4'd12;
   localparam logic [3:0] StNext   = 4'd13;
   localparam logic [3:0] StHalt   = 4'd14;
   localparam logic [3:0] StError  = 4'd15;

   localparam logic [OP_W-1:0] OpPush  = OP_W'(0);
   localparam logic [OP_W-1:0] OpPushI = OP_W'(1);
   localparam logic [OP_W-1:0] OpPushT = OP_W'(2);
   localparam logic [OP_W-1:0] OpPop   = OP_W'(3);
   localparam logic [OP_W-1:0] OpAluLo = OP_W'(4);
   localparam logic [OP_W-1:0] OpAluHi = OP_W'(12);
   localparam logic [OP_W-1:0] OpNot   = OP_W'(13);
   localparam logic [OP_W-1:0] OpGoto  = OP_W'(14);
   localparam logic [OP_W-1:0] OpCndLo = OP_W'(15);
   localparam logic [OP_W-1:0] OpCndHi = OP_W'(19);
   localparam logic [OP_W-1:0] OpHalt  = OP_W'(20);

   logic [3:0]             state_q, state_d;
   logic [PC_W-1:0]        pc_q, pc_d;
   logic [OP_W+ADDR_W-1:0] ir_q, ir_d;
   logic [SP_W-1:0]        sp_q, sp_d;
   logic [1:0]             cod_q, cod_d;
   logic                   taken_q, taken_d;

   logic [OP_W-1:0]   inst_op, ir_op;
   logic [ADDR_W-1:0] inst_arg, ir_arg;
   logic [1:0]        dec_pops;
   logic              dec_net_push, dec_illegal, dec_underflow, dec_overflow;
   logic              ir_is_alu, ir_is_cond;

   assign inst_op  = inst[OP_W+ADDR_W-1 -: OP_W];
   assign inst_arg = inst[ADDR_W-1:0];
   assign ir_op    = ir_q[OP_W+ADDR_W-1 -: OP_W];
   assign ir_arg   = ir_q[ADDR_W-1:0];

   assign ir_is_alu  = ir_op inside {[OpAluLo:OpAluHi]};
   assign ir_is_cond = ir_op inside {[OpCndLo:OpCndHi]};

   // Stack demand of the instruction arriving on inst; pushes that follow pops cannot overflow.
   always_comb begin
      dec_pops     = 2'd0;
      dec_net_push = 1'b0;
      dec_illegal  = 1'b0;
      if (inst_op > OpHalt) begin
         dec_illegal = 1'b1;
      end else if (inst_op inside {[OpAluLo:OpAluHi]}) begin
         dec_pops = 2'd2;
      end else if ((inst_op == OpPop) || (inst_op == OpNot) ||
                   (inst_op inside {[OpCndLo:OpCndHi]})) begin
         dec_pops = 2'd1;
      end else if (inst_op inside {OpPush, OpPushI, OpPushT}) begin
         dec_net_push = 1'b1;
      end
   end

   assign dec_underflow = 32'(dec_pops) > 32'(sp_q);
   assign dec_overflow  = dec_net_push && (sp_q == SP_W'(STACK_DEPTH));

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      sp_d    = sp_q;
      cod_d   = cod_q;
      taken_d = taken_q;
      case (state_q)
         StIdle, StHalt, StError: begin
            if (start) begin
               pc_d    = '0;
               sp_d    = '0;
               cod_d   = 2'd0;
               taken_d = 1'b0;
               state_d = StFetch;
            end
         end
         StFetch: state_d = StDecode;
         StDecode: begin
            ir_d = inst;
            if (dec_illegal) begin
               cod_d   = 2'd3;
               state_d = StError;
            end else if (dec_underflow) begin
               cod_d   = 2'd2;
               state_d = StError;
            end else if (dec_overflow) begin
               cod_d   = 2'd1;
               state_d = StError;
            end else if (inst_op == OpPush) begin
               state_d = StRd;
            end else if (inst_op == OpPushI) begin
               state_d = StPushWr;
            end else if (inst_op == OpPushT) begin
               state_d = StExec;
            end else if (inst_op == OpGoto) begin
               pc_d    = PC_W'(inst_arg);
               state_d = StFetch;
            end else if (inst_op == OpHalt) begin
               state_d = StHalt;
            end else begin
               state_d = StPopA;
            end
         end
         StRd: state_d = StPushWr;
         StPushWr: begin
            sp_d    = sp_q + SP_W'(1);
            state_d = StNext;
         end
         StExec: state_d = ir_is_cond ? StBrEval : StWb;
         StWb: begin
            sp_d    = sp_q + SP_W'(1);
            state_d = StNext;
         end
         StPopA: begin
            sp_d    = sp_q - SP_W'(1);
            state_d = (ir_op == OpPop) ? StWr : StLoadA;
         end
         StWr:    state_d = StNext;
         StLoadA: state_d = ir_is_alu ? StPopB : StExec;
         StPopB: begin
            sp_d    = sp_q - SP_W'(1);
            state_d = StLoadB;
         end
         StLoadB: state_d = StExec;
         // A taken branch still goes through NEXT so both outcomes cost the same cycles.
         StBrEval: begin
            taken_d = controle_ula;
            state_d = StNext;
         end
         StNext: begin
            pc_d    = taken_q ? PC_W'(ir_arg) : pc_q + PC_W'(1);
            taken_d = 1'b0;
            state_d = StFetch;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         pc_q    <= '0;
         ir_q    <= '0;
         sp_q    <= '0;
         cod_q   <= 2'd0;
         taken_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         sp_q    <= sp_d;
         cod_q   <= cod_d;
         taken_q <= taken_d;
      end
   end

   always_comb begin
      rom_en         = (state_q == StFetch);
      ram_en         = (state_q == StRd) || (state_q == StWr);
      ram_wren       = (state_q == StWr);
      pilha_en       = (state_q == StPushWr) || (state_q == StWb) ||
                       (state_q == StPopA)   || (state_q == StPopB);
      pilha_wren     = (state_q == StPushWr) || (state_q == StWb);
      controle_pilha = (state_q == StWb);
      load_temp1     = (state_q == StLoadA);
      load_temp2     = (state_q == StLoadB);
      data_pilha     = '0;
      if (state_q == StPushWr) begin
         data_pilha = (ir_op == OpPush) ? data_mem : DATA_W'(ir_arg);
      end
      opcode   = (state_q inside {StIdle, StFetch, StDecode}) ? '0 : ir_op;
      busy     = !(state_q inside {StIdle, StHalt, StError});
      halted   = (state_q == StHalt);
      erro     = (state_q == StError);
      erro_cod = cod_q;
      sp       = sp_q;
      a_rom    = pc_q;
      a_ram    = ir_arg;
   end

endmodule

// File: tb/tb_uc_pilha_param.sv
// Bench for uc_pilha_param: per-opcode vector table, hand sequences for multi-cycle corners,
// and random programs checked against an instruction-level reference model.

module tb_uc_pilha_param;

   localparam int DW   = 16;
   localparam int AW   = 5;
   localparam int PW   = 5;
   localparam int OW   = 5;
   localparam int SD   = 16;
   localparam int SPW  = $clog2(SD + 1);
   localparam int SPW2 = $clog2(3);

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic controle_ula = 1'b0;
   logic [OW+AW-1:0] inst = '0, inst2 = '0;
   logic [DW-1:0] data_mem = '0, data_mem2 = '0;

   logic [PW-1:0] a_rom, a_rom2;
   logic [AW-1:0] a_ram, a_ram2;
   logic rom_en, ram_en, ram_wren, pilha_en, pilha_wren, controle_pilha, load_temp1, load_temp2;
   logic rom_en2, ram_en2, ram_wren2, pilha_en2, pilha_wren2, controle_pilha2;
   logic load_temp12, load_temp22;
   logic [DW-1:0] data_pilha, data_pilha2;
   logic [OW-1:0] opcode, opcode2;
   logic [SPW-1:0] sp;
   logic [SPW2-1:0] sp2;
   logic busy, halted, erro, busy2, halted2, erro2;
   logic [1:0] erro_cod, erro_cod2;

   always #5 clock = ~clock;

   uc_pilha_param dut (
      .clock(clock), .reset(reset), .start(start), .inst(inst), .data_mem(data_mem),
      .controle_ula(controle_ula), .a_rom(a_rom), .rom_en(rom_en), .a_ram(a_ram),
      .ram_en(ram_en), .ram_wren(ram_wren), .pilha_en(pilha_en), .pilha_wren(pilha_wren),
      .controle_pilha(controle_pilha), .data_pilha(data_pilha), .load_temp1(load_temp1),
      .load_temp2(load_temp2), .opcode(opcode), .sp(sp), .busy(busy), .halted(halted),
      .erro(erro), .erro_cod(erro_cod)
   );

   uc_pilha_param #(.STACK_DEPTH(2)) dut2 (
      .clock(clock), .reset(reset), .start(start), .inst(inst2), .data_mem(data_mem2),
      .controle_ula(controle_ula), .a_rom(a_rom2), .rom_en(rom_en2), .a_ram(a_ram2),
      .ram_en(ram_en2), .ram_wren(ram_wren2), .pilha_en(pilha_en2), .pilha_wren(pilha_wren2),
      .controle_pilha(controle_pilha2), .data_pilha(data_pilha2), .load_temp1(load_temp12),
      .load_temp2(load_temp22), .opcode(opcode2), .sp(sp2), .busy(busy2), .halted(halted2),
      .erro(erro2), .erro_cod(erro_cod2)
   );

   logic [OW+AW-1:0] rom [32];
   logic [DW-1:0]    ram [32];

   int n_cmp = 0;
   int n_bad = 0;

   int m_lat, m_pil, m_lt1, m_lt2, m_wb, m_opc;
   logic [DW-1:0] m_push [$];
   logic [AW-1:0] m_wr [$];

   typedef struct {
      int pre; int op; int arg; bit cu;
      int lat; int pil; int spx; int nxt; int st; int cod;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [OW+AW-1:0] mk(input int op, input int arg);
      return {OW'(op), AW'(arg)};
   endfunction

   function automatic logic [OW+AW-1:0] rand_inst();
      int r;
      int op;
      r = $urandom_range(0, 99);
      if (r < 10)      op = 0;
      else if (r < 35) op = 1;
      else if (r < 42) op = 2;
      else if (r < 52) op = 3;
      else if (r < 72) op = $urandom_range(4, 12);
      else if (r < 78) op = 13;
      else if (r < 83) op = 14;
      else if (r < 93) op = $urandom_range(15, 19);
      else if (r < 95) op = 20;
      else             op = $urandom_range(21, 31);
      return mk(op, $urandom_range(0, 31));
   endfunction

   // ROM/RAM respond one cycle after their strobes; called at a falling edge.
   task automatic cyc();
      logic re, me, mw, re2, me2, mw2;
      logic [PW-1:0] ra, ra2;
      logic [AW-1:0] aa, aa2;
      re = rom_en;   ra = a_rom;   me = ram_en;   mw = ram_wren;   aa = a_ram;
      re2 = rom_en2; ra2 = a_rom2; me2 = ram_en2; mw2 = ram_wren2; aa2 = a_ram2;
      @(posedge clock);
      #1;
      if (re) inst = rom[ra];
      if (me && !mw) data_mem = ram[aa];
      if (re2) inst2 = rom[ra2];
      if (me2 && !mw2) data_mem2 = ram[aa2];
      @(negedge clock);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b0;
      start = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   // Runs one instruction from its FETCH cycle to the next FETCH or a stop state.
   task automatic measure();
      m_lat = 0; m_pil = 0; m_lt1 = -1; m_lt2 = -1; m_wb = 0; m_opc = -1;
      m_push.delete();
      m_wr.delete();
      do begin
         if (pilha_en) m_pil++;
         if (pilha_en && pilha_wren && !controle_pilha) m_push.push_back(data_pilha);
         if (pilha_en && pilha_wren && controle_pilha) m_wb++;
         if (ram_en && ram_wren) m_wr.push_back(a_ram);
         if (load_temp1) m_lt1 = m_lat;
         if (load_temp2) m_lt2 = m_lat;
         if (m_lat == 2) m_opc = int'(opcode);
         cyc();
         m_lat++;
      end while (!rom_en && busy && m_lat < 16);
   endtask

   // Instruction-level reference: stack demand, cost and successor pc of one instruction.
   task automatic model(input int op, input int arg, input bit cu, input int pc, input int spv,
                        output int pops, output int push, output int lat, output int trap,
                        output bit halt, output int nxt);
      pops = 0; push = 0; lat = 0; trap = 0; halt = 1'b0; nxt = (pc + 1) % 32;
      if (op == 0)       begin push = 1; lat = 5; end
      else if (op == 1)  begin push = 1; lat = 4; end
      else if (op == 2)  begin push = 1; lat = 5; end
      else if (op == 3)  begin pops = 1; lat = 5; end
      else if (op <= 12) begin pops = 2; push = 1; lat = 9; end
      else if (op == 13) begin pops = 1; push = 1; lat = 7; end
      else if (op == 14) begin lat = 2; nxt = arg; end
      else if (op <= 19) begin pops = 1; lat = 7; if (cu) nxt = arg; end
      else if (op == 20) begin halt = 1'b1; lat = 2; end
      else trap = 3;
      if (trap == 0 && pops > spv) trap = 2;
      else if (trap == 0 && push > pops && spv == SD) trap = 1;
      if (trap != 0) begin halt = 1'b0; pops = 0; push = 0; lat = 2; end
   endtask

   initial begin
      vec_t vecs[$];
      vec_t v;
      int op, arg, pops, push, lat, trap, nxt, m_pc, m_sp, exp_n;
      bit cu, hlt, stop, seen;
      logic [DW-1:0] exp_val;

      for (int a = 0; a < 32; a++) ram[a] = 16'hA000 + 16'(a);
      ram[3] = 16'hBEEF;

      #1 reset = 1'b0;
      repeat (2) @(negedge clock);
      chk("rst rom_en", rom_en, 0);
      chk("rst ram_en", ram_en, 0);
      chk("rst pilha_en", pilha_en, 0);
      chk("rst busy", busy, 0);
      chk("rst halted", halted, 0);
      chk("rst erro", erro, 0);
      chk("rst erro_cod", erro_cod, 0);
      chk("rst sp", sp, 0);
      chk("rst a_rom", a_rom, 0);
      chk("rst data_pilha", data_pilha, 0);
      chk("rst opcode", opcode, 0);
      reset = 1'b1;

      //            pre op arg cu lat pil sp nxt st cod
      vecs.push_back('{0,  1,  9, 0, 4, 1,  1,  1, 0, 0});
      vecs.push_back('{0,  0,  3, 0, 5, 1,  1,  1, 0, 0});
      vecs.push_back('{0,  2,  0, 0, 5, 1,  1,  1, 0, 0});
      vecs.push_back('{1,  3,  9, 0, 5, 1,  0,  2, 0, 0});
      vecs.push_back('{2,  4,  0, 0, 9, 3,  1,  3, 0, 0});
      vecs.push_back('{2, 12,  0, 0, 9, 3,  1,  3, 0, 0});
      vecs.push_back('{1, 13,  0, 0, 7, 2,  1,  2, 0, 0});
      vecs.push_back('{0, 14, 17, 0, 2, 0,  0, 17, 0, 0});
      vecs.push_back('{4, 15, 10, 1, 7, 1,  3, 10, 0, 0});
      vecs.push_back('{4, 19, 10, 0, 7, 1,  3,  5, 0, 0});
      vecs.push_back('{0, 20,  0, 0, 2, 0,  0,  0, 1, 0});
      vecs.push_back('{3, 20,  0, 0, 2, 0,  3,  3, 1, 0});
      vecs.push_back('{1,  4,  0, 0, 2, 0,  1,  0, 2, 2});
      vecs.push_back('{0,  3,  0, 0, 2, 0,  0,  0, 2, 2});
      vecs.push_back('{0, 17,  4, 1, 2, 0,  0,  0, 2, 2});
      vecs.push_back('{0, 25,  0, 0, 2, 0,  0,  0, 2, 3});
      vecs.push_back('{2, 21,  0, 0, 2, 0,  2,  0, 2, 3});
      vecs.push_back('{16, 1,  5, 0, 2, 0, 16,  0, 2, 1});
      vecs.push_back('{16, 0,  3, 0, 2, 0, 16,  0, 2, 1});
      vecs.push_back('{16, 4,  0, 0, 9, 3, 15, 17, 0, 0});
      vecs.push_back('{16,13,  0, 0, 7, 2, 16, 17, 0, 0});

      foreach (vecs[i]) begin
         v = vecs[i];
         do_reset();
         for (int a = 0; a < 32; a++) rom[a] = mk(20, 0);
         for (int a = 0; a < v.pre; a++) rom[a] = mk(1, a + 1);
         rom[v.pre] = mk(v.op, v.arg);
         controle_ula = v.cu;
         pulse_start();
         repeat (v.pre) measure();
         measure();
         chk($sformatf("vec%0d latency", i), m_lat, v.lat);
         chk($sformatf("vec%0d pilha_en count", i), m_pil, v.pil);
         chk($sformatf("vec%0d sp", i), sp, v.spx);
         chk($sformatf("vec%0d busy", i), busy, (v.st == 0));
         if (v.lat > 2) chk($sformatf("vec%0d opcode", i), m_opc, v.op);
         if (v.st == 0) chk($sformatf("vec%0d next a_rom", i), a_rom, v.nxt);
         if (v.st == 1) begin
            chk($sformatf("vec%0d halted", i), halted, 1);
            chk($sformatf("vec%0d halt pc", i), a_rom, v.nxt);
         end
         if (v.st == 2) begin
            chk($sformatf("vec%0d erro", i), erro, 1);
            chk($sformatf("vec%0d erro_cod", i), erro_cod, v.cod);
         end
      end

      // Two immediates, an ALU op, HALT
      do_reset();
      for (int a = 0; a < 32; a++) rom[a] = mk(20, 0);
      rom[0] = mk(1, 7); rom[1] = mk(1, 5); rom[2] = mk(4, 0); rom[3] = mk(20, 0);
      controle_ula = 1'b0;
      pulse_start();
      measure();
      chk("seqA push count 1", m_push.size(), 1);
      if (m_push.size() > 0) chk("seqA push 7", m_push[0], 7);
      chk("seqA sp 1", sp, 1);
      measure();
      if (m_push.size() > 0) chk("seqA push 5", m_push[0], 5);
      chk("seqA sp 2", sp, 2);
      measure();
      chk("seqA load_temp1 cycle", m_lt1, 3);
      chk("seqA load_temp2 cycle", m_lt2, 5);
      chk("seqA wb push", m_wb, 1);
      chk("seqA sp back to 1", sp, 1);
      measure();
      chk("seqA halted", halted, 1);
      chk("seqA halt pc", a_rom, 3);

      // RAM push then pop to another address
      do_reset();
      rom[0] = mk(0, 3); rom[1] = mk(3, 9); rom[2] = mk(20, 0);
      pulse_start();
      measure();
      chk("seqB push count", m_push.size(), 1);
      if (m_push.size() > 0) chk("seqB push data", m_push[0], 16'hBEEF);
      measure();
      chk("seqB ram write count", m_wr.size(), 1);
      if (m_wr.size() > 0) chk("seqB ram write addr", m_wr[0], 9);
      chk("seqB sp", sp, 0);

      // Depth-2 instance overflows on the third push
      do_reset();
      for (int a = 0; a < 32; a++) rom[a] = mk(20, 0);
      rom[0] = mk(1, 1); rom[1] = mk(1, 2); rom[2] = mk(1, 3);
      pulse_start();
      repeat (14) cyc();
      chk("seqD depth2 erro", erro2, 1);
      chk("seqD depth2 erro_cod", erro_cod2, 1);
      chk("seqD depth2 sp", sp2, 2);
      chk("seqD depth2 pc", a_rom2, 2);
      chk("seqD depth16 halted", halted, 1);
      chk("seqD depth16 sp", sp, 3);

      // pc wraps from the top of ROM
      do_reset();
      for (int a = 0; a < 32; a++) rom[a] = mk(20, 0);
      rom[0] = mk(14, 31); rom[31] = mk(1, 1);
      pulse_start();
      measure();
      chk("seqE goto 31", a_rom, 31);
      measure();
      chk("seqE wrap a_rom", a_rom, 0);
      chk("seqE wrap rom_en", rom_en, 1);

      // start while busy is ignored
      do_reset();
      for (int a = 0; a < 32; a++) rom[a] = mk(20, 0);
      rom[0] = mk(1, 1); rom[1] = mk(1, 2);
      pulse_start();
      measure();
      cyc();
      start = 1'b1;
      cyc();
      cyc();
      start = 1'b0;
      cyc();
      chk("seqF busy start rom_en", rom_en, 1);
      chk("seqF busy start a_rom", a_rom, 2);
      chk("seqF busy start sp", sp, 2);

      // start from ERROR restarts cleanly
      do_reset();
      rom[0] = mk(1, 1); rom[1] = mk(4, 0);
      pulse_start();
      measure();
      measure();
      chk("seqG erro", erro, 1);
      chk("seqG erro_cod", erro_cod, 2);
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk("seqG restart rom_en", rom_en, 1);
      chk("seqG restart a_rom", a_rom, 0);
      chk("seqG restart erro", erro, 0);
      chk("seqG restart erro_cod", erro_cod, 0);
      chk("seqG restart sp", sp, 0);

      // Reset dropped during LOAD_B
      do_reset();
      rom[0] = mk(1, 1); rom[1] = mk(1, 2); rom[2] = mk(4, 0); rom[3] = mk(20, 0);
      pulse_start();
      measure();
      measure();
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         if (load_temp2) seen = 1'b1;
         else cyc();
      end
      chk("seqH reached LOAD_B", seen, 1);
      reset = 1'b0;
      #1;
      chk("seqH load_temp2", load_temp2, 0);
      chk("seqH pilha_en", pilha_en, 0);
      chk("seqH rom_en", rom_en, 0);
      chk("seqH ram_en", ram_en, 0);
      chk("seqH busy", busy, 0);
      chk("seqH sp", sp, 0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk("seqH idle after release", busy, 0);
      pulse_start();
      chk("seqH refetch rom_en", rom_en, 1);
      chk("seqH refetch a_rom", a_rom, 0);

      // Random programs against the instruction-level model
      for (int r = 0; r < 30; r++) begin
         do_reset();
         for (int a = 0; a < 32; a++) begin
            rom[a] = rand_inst();
            ram[a] = 16'($urandom);
         end
         pulse_start();
         m_pc = 0; m_sp = 0; stop = 1'b0;
         for (int k = 0; k < 40 && !stop; k++) begin
            op  = int'(rom[m_pc][OW+AW-1:AW]);
            arg = int'(rom[m_pc][AW-1:0]);
            cu  = 1'($urandom_range(0, 1));
            controle_ula = cu;
            chk("rnd fetch pc", {rom_en, a_rom}, {1'b1, PW'(m_pc)});
            chk("rnd fetch sp", sp, m_sp);
            model(op, arg, cu, m_pc, m_sp, pops, push, lat, trap, hlt, nxt);
            measure();
            chk("rnd latency", m_lat, lat);
            if (trap != 0) begin
               chk("rnd trap erro", erro, 1);
               chk("rnd trap code", erro_cod, trap);
               chk("rnd trap no stack", m_pil, 0);
               stop = 1'b1;
            end else if (hlt) begin
               chk("rnd halted", halted, 1);
               chk("rnd halt pc", a_rom, m_pc);
               stop = 1'b1;
            end else begin
               chk("rnd pilha_en count", m_pil, pops + push);
               exp_n   = (op <= 1) ? 1 : 0;
               exp_val = (op == 0) ? ram[arg] : 16'(arg);
               chk("rnd push count", m_push.size(), exp_n);
               if (m_push.size() > 0 && exp_n > 0) chk("rnd push data", m_push[0], exp_val);
               chk("rnd ram write count", m_wr.size(), (op == 3));
               if (m_wr.size() > 0 && op == 3) chk("rnd ram write addr", m_wr[0], arg);
               m_sp = m_sp + push - pops;
               m_pc = nxt;
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
